alu_cmd_issuer: RTL

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_cmd_fifo.sv | 41 ++++
 rtl/alu_cmd_issuer.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, issuer FSM states and response flag layout shared by the ALU command issuer
// Contents: OP_* opcode constants, FLAG_* bit indices into rsp_flags, state_t, pack_flags()
package alu_pkg;
  localparam logic [3:0] OP_ADD     = 4'b0000;
  localparam logic [3:0] OP_SUB     = 4'b0001;
  localparam logic [3:0] OP_AND     = 4'b0010;
  localparam logic [3:0] OP_OR      = 4'b0011;
  localparam logic [3:0] OP_XOR     = 4'b0100;
  localparam logic [3:0] OP_MUL     = 4'b0101;
  localparam logic [3:0] OP_SHL     = 4'b0110;
  localparam logic [3:0] OP_TANH    = 4'b0111;
  localparam logic [3:0] OP_MAC     = 4'b1000;
  localparam logic [3:0] OP_ILLEGAL = 4'b1111;
  localparam int FLAG_CARRY  = 0;
  localparam int FLAG_BORROW = 1;
  localparam int FLAG_ZERO   = 2;
  localparam int FLAG_ERR    = 3;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  function automatic logic [3:0] pack_flags(input logic err, input logic zero, input logic borrow, input logic carry);
    logic [3:0] f;
    f = '0;
    f[FLAG_ERR]    = err;
    f[FLAG_ZERO]   = zero;
    f[FLAG_BORROW] = borrow;
    f[FLAG_CARRY]  = carry;
    return f;
  endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: DEPTH-entry command FIFO holding {opcode, a, b}, simultaneous push/pop supported
// Ports: clk, rst (async active-low), push/din, pop/dout (head, valid when !empty), full, empty
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [2*WIDTH+3:0] din,
  input  logic               pop,
  output logic [2*WIDTH+3:0] dout,
  output logic               full,
  output logic               empty
);
  localparam int AW = $clog2(DEPTH);
  logic [2*WIDTH+3:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign dout    = mem[rd_ptr];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands, issues them one at a time to a fixed-latency ALU, returns responses in order
// Ports: clk, rst (async active-low); cmd_* command stream in; alu_* drive to / results from the ALU;
//        rsp_* response stream out ({err,zero,borrow,carry} flags).
// Option: define ALU_ISSUER_STATS_EN to add issue_count (legal completions) and err_count (illegal opcodes).
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic [3:0]         cmd_opcode,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_opcode,
  output logic               alu_enable,
  input  logic [2*WIDTH-1:0] alu_result,
  input  logic               alu_carry,
  input  logic               alu_borrow,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic [3:0]         rsp_flags,
  output logic [3:0]         rsp_opcode
`ifdef ALU_ISSUER_STATS_EN
  ,
  output logic [15:0]        issue_count,
  output logic [7:0]         err_count
`endif
);
  state_t state, state_nx;
  logic ready_en, push, pop, full, empty, busy, head_illegal;
  logic [2*WIDTH+3:0] head;
  logic [WIDTH-1:0] cur_a, cur_b;
  logic [3:0] cur_op;
  alu_cmd_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({cmd_opcode, cmd_a, cmd_b}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  // ready_en keeps cmd_ready low during reset and rises on the first edge after release
  assign cmd_ready    = ready_en && !full;
  assign push         = cmd_valid && cmd_ready;
  assign pop          = state == S_IDLE && !empty;
  assign head_illegal = head[2*WIDTH +: 4] == OP_ILLEGAL;
  assign busy         = state == S_ISSUE || state == S_WAIT;
  assign alu_a        = busy ? cur_a : '0;
  assign alu_b        = busy ? cur_b : '0;
  assign alu_opcode   = busy ? cur_op : '0;
  assign alu_enable   = state == S_ISSUE && cur_op == OP_MAC;
  assign rsp_valid    = state == S_RESP;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = empty ? S_IDLE : (head_illegal ? S_RESP : S_ISSUE);
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  state_nx = S_RESP;
      S_RESP:  state_nx = rsp_ready ? S_IDLE : S_RESP;
      default: state_nx = S_IDLE;
    endcase
  end
  // illegal commands build their response at pop time; legal ones capture the ALU at the end of WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en   <= 1'b0;
      cur_a      <= '0;
      cur_b      <= '0;
      cur_op     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_opcode <= '0;
    end else begin
      ready_en <= 1'b1;
      if (pop) begin
        cur_op <= head[2*WIDTH +: 4];
        cur_a  <= head[WIDTH +: WIDTH];
        cur_b  <= head[0 +: WIDTH];
      end
      if (pop && head_illegal) begin
        rsp_result <= '0;
        rsp_flags  <= pack_flags(1'b1, 1'b0, 1'b0, 1'b0);
        rsp_opcode <= OP_ILLEGAL;
      end
      if (state == S_WAIT) begin
        rsp_result <= alu_result;
        rsp_flags  <= pack_flags(1'b0, alu_zero, alu_borrow, alu_carry);
        rsp_opcode <= cur_op;
      end
    end
  end
`ifdef ALU_ISSUER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_count <= '0;
      err_count   <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (rsp_flags[FLAG_ERR]) err_count <= err_count + 8'd1;
      else issue_count <= issue_count + 16'd1;
    end
  end
`endif
endmodule
